// File: rtl/pipeline.sv
// Shared IFU/decode definitions: datapath width, fetch FSM states and
// the RV32C length test.
package pipeline;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FETCH_HI
  } fetch_state_t;

  // Any opcode whose two low bits are not 2'b11 is a 16-bit instruction
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Turns the current PC into an aligned instruction for decode, using a
// one-word line buffer and a word-aligned memory request/ack port.
module fetch_aligner #(
  parameter int unsigned XLEN = pipeline::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] curr_pc,
  input  logic            flush,
  input  logic            id_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            compressed,
  output logic            stall
);

  import pipeline::fetch_state_t, pipeline::IDLE, pipeline::FETCH,
         pipeline::FETCH_HI, pipeline::is_rvc;

  localparam int unsigned TAG_W = XLEN - 2;

  fetch_state_t     state_q;
  fetch_state_t     state_d;

  logic [31:0]      buf_word;
  logic [TAG_W-1:0] buf_tag;
  logic             buf_valid;

  logic             req_d;
  logic [XLEN-1:0]  addr_d;
  logic [31:0]      instr_q;
  logic [31:0]      instr_d;
  logic             compressed_q;
  logic             compressed_d;
  logic             valid_d;
  logic             clear_buf;

  logic             hit;
  logic             ack;
  logic [15:0]      half;
  logic             unused_pc_lsb;

  // Bit 0 of the PC is always zero
  assign unused_pc_lsb = curr_pc[0];

  // Only an ack against an outstanding request counts
  assign ack  = imem_req && imem_ack;
  assign hit  = buf_valid && (buf_tag == curr_pc[XLEN-1:2]);
  assign half = curr_pc[1] ? buf_word[31:16] : buf_word[15:0];

  // Next state, next request and the same-cycle instruction
  always_comb begin
    state_d      = state_q;
    req_d        = imem_req;
    addr_d       = imem_addr;
    instr_d      = instr_q;
    compressed_d = compressed_q;
    valid_d      = 1'b0;
    clear_buf    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clear_buf = flush;
        if (!hit) begin
          req_d   = 1'b1;
          addr_d  = {curr_pc[XLEN-1:2], 2'b00};
          state_d = FETCH;
        end else if (is_rvc(half[1:0])) begin
          instr_d      = {16'h0000, half};
          compressed_d = 1'b1;
          valid_d      = 1'b1;
        end else if (!curr_pc[1]) begin
          instr_d      = buf_word;
          compressed_d = 1'b0;
          valid_d      = 1'b1;
        end else begin
          // 32-bit instruction straddles into the next word
          req_d   = 1'b1;
          addr_d  = {curr_pc[XLEN-1:2] + TAG_W'(1), 2'b00};
          state_d = FETCH_HI;
        end
      end

      FETCH: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      FETCH_HI: begin
        if (ack) begin
          req_d        = 1'b0;
          state_d      = IDLE;
          instr_d      = {imem_rdata[15:0], buf_word[31:16]};
          compressed_d = 1'b0;
          valid_d      = 1'b1;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign instr       = instr_d;
  assign compressed  = compressed_d;
  assign instr_valid = valid_d;
  assign stall       = !(valid_d && id_ready);

  // FSM, request port and last-delivered instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      instr_q      <= '0;
      compressed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_req     <= req_d;
      imem_addr    <= addr_d;
      instr_q      <= instr_d;
      compressed_q <= compressed_d;
    end
  end

  // Line buffer: every accepted ack refills it; flush only reaches it in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_word  <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
    end else if (ack) begin
      buf_word  <= imem_rdata;
      buf_tag   <= imem_addr[XLEN-1:2];
      buf_valid <= 1'b1;
    end else if (clear_buf) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: hand-driven memory handshake and
// hand-computed instruction/handshake expectations.
module tb_fetch_aligner;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] curr_pc;
  logic            flush;
  logic            id_ready;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            compressed;
  logic            stall;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fetch_aligner #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .curr_pc    (curr_pc),
    .flush      (flush),
    .id_ready   (id_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .compressed (compressed),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check it, hold off ack for 'delay' cycles,
  // then drive ack with 'data'. Returns inside the ack cycle.
  task automatic serve(input string tag, input logic [31:0] addr,
                       input logic [31:0] data, input int delay);
    int n = 0;
    while (!imem_req && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, " req"}, 32'(imem_req), 32'd1);
    chk({tag, " addr"}, imem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      chk({tag, " wait stall"}, 32'(stall), 32'd1);
      chk({tag, " wait addr"}, imem_addr, addr);
      chk({tag, " wait req"}, 32'(imem_req), 32'd1);
      cyc();
      #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    curr_pc    = '0;
    flush      = 1'b0;
    id_ready   = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;

    // Reset values
    cyc();
    cyc();
    #1;
    chk("rst req", 32'(imem_req), 32'd0);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst compressed", 32'(compressed), 32'd0);
    chk("rst stall", 32'(stall), 32'd1);

    // Cold miss at 0, ack one cycle after the request
    cyc();
    reset_n = 1'b1;
    #1;
    chk("t1 miss valid", 32'(instr_valid), 32'd0);
    serve("t1", 32'h0, 32'h0000_0013, 1);
    chk("t1 ack-cycle valid", 32'(instr_valid), 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t1 instr", instr, 32'h0000_0013);
    chk("t1 compressed", 32'(compressed), 32'd0);
    chk("t1 valid", 32'(instr_valid), 32'd1);
    chk("t1 stall", 32'(stall), 32'd0);
    chk("t1 req dropped", 32'(imem_req), 32'd0);

    // Flush, then two compressed halves out of one word
    flush = 1'b1;
    #1;
    chk("t2 flush same-cycle valid", 32'(instr_valid), 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("t2 miss after flush", 32'(instr_valid), 32'd0);
    serve("t2", 32'h0, 32'h4501_4505, 0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t2 lo instr", instr, 32'h0000_4505);
    chk("t2 lo compressed", 32'(compressed), 32'd1);
    chk("t2 lo valid", 32'(instr_valid), 32'd1);
    cyc();
    curr_pc = 32'h2;
    #1;
    chk("t2 hi instr", instr, 32'h0000_4501);
    chk("t2 hi compressed", 32'(compressed), 32'd1);
    chk("t2 hi no req", 32'(imem_req), 32'd0);
    cyc();
    #1;
    chk("t2 still no req", 32'(imem_req), 32'd0);

    // 32-bit instruction at 6 straddling words 4 and 8
    cyc();
    curr_pc = 32'h6;
    #1;
    chk("t3 miss valid", 32'(instr_valid), 32'd0);
    serve("t3 lo", 32'h4, 32'h0013_4505, 0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t3 straddle no valid", 32'(instr_valid), 32'd0);
    chk("t3 straddle stall", 32'(stall), 32'd1);
    serve("t3 hi", 32'h8, 32'h1234_0000, 0);
    chk("t3 instr", instr, 32'h0000_0013);
    chk("t3 compressed", 32'(compressed), 32'd0);
    chk("t3 valid", 32'(instr_valid), 32'd1);
    chk("t3 stall", 32'(stall), 32'd0);
    cyc();
    imem_ack = 1'b0;
    curr_pc  = 32'hA;
    #1;
    chk("t3 next hit instr", instr, 32'h0000_1234);
    chk("t3 next hit compressed", 32'(compressed), 32'd1);
    chk("t3 next hit no req", 32'(imem_req), 32'd0);

    // Miss with a 3-cycle ack delay
    cyc();
    curr_pc = 32'h100;
    #1;
    serve("t4 delayed", 32'h100, 32'h00A0_0093, 3);
    chk("t4 delayed ack-cycle valid", 32'(instr_valid), 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t4 delayed instr", instr, 32'h00A0_0093);
    chk("t4 delayed valid", 32'(instr_valid), 32'd1);
    chk("t4 delayed compressed", 32'(compressed), 32'd0);
    chk("t4 delayed stall", 32'(stall), 32'd0);

    // Miss with zero-wait ack
    cyc();
    curr_pc = 32'h200;
    #1;
    serve("t4 zero", 32'h200, 32'h00B0_0113, 0);
    chk("t4 zero ack-cycle valid", 32'(instr_valid), 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t4 zero instr", instr, 32'h00B0_0113);
    chk("t4 zero valid", 32'(instr_valid), 32'd1);

    // Decode back-pressure on a pending hit
    id_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5 valid", 32'(instr_valid), 32'd1);
      chk("t5 stall", 32'(stall), 32'd1);
      chk("t5 instr", instr, 32'h00B0_0113);
      chk("t5 no req", 32'(imem_req), 32'd0);
      cyc();
      #1;
    end
    id_ready = 1'b1;
    #1;
    chk("t5 release stall", 32'(stall), 32'd0);

    // Flush in IDLE forces a refetch of the same word
    flush = 1'b1;
    #1;
    chk("t6 flush same-cycle valid", 32'(instr_valid), 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("t6 miss after flush", 32'(instr_valid), 32'd0);
    cyc();
    #1;
    chk("t6 refetch req", 32'(imem_req), 32'd1);
    chk("t6 refetch addr", imem_addr, 32'h200);

    // Reset in the middle of FETCH, with a stray ack right after release
    reset_n = 1'b0;
    #1;
    chk("t6 reset req", 32'(imem_req), 32'd0);
    chk("t6 reset addr", imem_addr, 32'h0);
    chk("t6 reset stall", 32'(stall), 32'd1);
    cyc();
    cyc();
    curr_pc    = 32'h0;
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6 stray ack no valid", 32'(instr_valid), 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t6 post-reset req", 32'(imem_req), 32'd1);
    chk("t6 post-reset addr", imem_addr, 32'h0);
    serve("t6 refetch", 32'h0, 32'h0000_0013, 0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t6 refetch instr", instr, 32'h0000_0013);
    chk("t6 refetch valid", 32'(instr_valid), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
